// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of every non-clock, non-reset signal of regfile_sb.
//   master : issue/writeback side (drives addresses, write data, issue, flush)
//   slave  : the register file (drives read data, busy flags and nbusy)
// Ports carried:
//   rs1, rs2          read addresses
//   rdata1, rdata2    read data (combinational)
//   busy1, busy2      scoreboard status of rs1/rs2 (combinational)
//   wen0/1, waddr0/1, wdata0/1   writeback ports 0 and 1
//   iss_valid, iss_rd issue that marks iss_rd busy
//   flush             clear whole scoreboard
//   nbusy             registered count of busy registers
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            busy1;
  logic            busy2;
  logic            wen0;
  logic            wen1;
  logic [AW-1:0]   waddr0;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic [AW:0]     nbusy;

  modport master (
    output rs1, rs2, wen0, wen1, waddr0, waddr1, wdata0, wdata1,
           iss_valid, iss_rd, flush,
    input  rdata1, rdata2, busy1, busy2, nbusy
  );

  modport slave (
    input  rs1, rs2, wen0, wen1, waddr0, waddr1, wdata0, wdata1,
           iss_valid, iss_rd, flush,
    output rdata1, rdata2, busy1, busy2, nbusy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 2-write integer register file with a per-register
// busy scoreboard for the dual-issue core.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : regfile_sb_if.slave (read ports, writeback ports, issue, flush,
//          busy flags and registered busy count)
// Register 0 reads zero, is never written and is never busy. Writeback
// port 1 wins over port 0 on an address collision, both for storage and
// for the bypass path. With BYPASS=1 a write in the current cycle is seen
// on the read ports and also hides the busy bit it is about to clear.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam bit USE_BYP = (BYPASS != 32'sd0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     nbusy_q;
  logic [AW:0]     nbusy_d;

  logic            hit1_p0_s;
  logic            hit1_p1_s;
  logic            hit2_p0_s;
  logic            hit2_p1_s;
  logic [XLEN-1:0] rdata1_s;
  logic [XLEN-1:0] rdata2_s;
  logic            busy1_s;
  logic            busy2_s;

  // Number of set bits; NREG-1 at most, so AW+1 bits never wrap.
  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // True when an enabled writeback port targets address a.
  function automatic logic wr_hit(input logic [AW-1:0] a,
                                  input logic w0, input logic [AW-1:0] a0,
                                  input logic w1, input logic [AW-1:0] a1);
    return (w0 && (a0 == a)) || (w1 && (a1 == a));
  endfunction

  // Next register contents; port 1 checked first so it wins collisions.
  always_comb begin
    regs_d[0] = {XLEN{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      if (bus.wen1 && (bus.waddr1 == AW'(i))) begin
        regs_d[i] = bus.wdata1;
      end else if (bus.wen0 && (bus.waddr0 == AW'(i))) begin
        regs_d[i] = bus.wdata0;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next scoreboard: flush > set > clear > hold. A set beats a clear
  // because the newly issued producer is still in flight.
  always_comb begin
    busy_d = {NREG{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      if (bus.flush) begin
        busy_d[i] = 1'b0;
      end else if (bus.iss_valid && (bus.iss_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_hit(AW'(i), bus.wen0, bus.waddr0, bus.wen1, bus.waddr1)) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    nbusy_d = popcount(busy_d);
  end

  // Register storage, busy bits and busy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      busy_q  <= {NREG{1'b0}};
      nbusy_q <= {(AW+1){1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  // Address match of each read port against each enabled write port.
  always_comb begin
    hit1_p0_s = bus.wen0 && (bus.waddr0 == bus.rs1);
    hit1_p1_s = bus.wen1 && (bus.waddr1 == bus.rs1);
    hit2_p0_s = bus.wen0 && (bus.waddr0 == bus.rs2);
    hit2_p1_s = bus.wen1 && (bus.waddr1 == bus.rs2);
  end

  // Read port 1. Gated by reset so live write data never leaks through
  // the bypass while the file is held in reset.
  always_comb begin
    if (!rst || (bus.rs1 == {AW{1'b0}})) begin
      rdata1_s = {XLEN{1'b0}};
      busy1_s  = 1'b0;
    end else begin
      if (USE_BYP && hit1_p1_s) begin
        rdata1_s = bus.wdata1;
      end else if (USE_BYP && hit1_p0_s) begin
        rdata1_s = bus.wdata0;
      end else begin
        rdata1_s = regs_q[bus.rs1];
      end
      busy1_s = busy_q[bus.rs1] && !(USE_BYP && (hit1_p0_s || hit1_p1_s));
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    if (!rst || (bus.rs2 == {AW{1'b0}})) begin
      rdata2_s = {XLEN{1'b0}};
      busy2_s  = 1'b0;
    end else begin
      if (USE_BYP && hit2_p1_s) begin
        rdata2_s = bus.wdata1;
      end else if (USE_BYP && hit2_p0_s) begin
        rdata2_s = bus.wdata0;
      end else begin
        rdata2_s = regs_q[bus.rs2];
      end
      busy2_s = busy_q[bus.rs2] && !(USE_BYP && (hit2_p0_s || hit2_p1_s));
    end
  end

  assign bus.rdata1 = rdata1_s;
  assign bus.rdata2 = rdata2_s;
  assign bus.busy1  = busy1_s;
  assign bus.busy2  = busy2_s;
  assign bus.nbusy  = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random stimulus for regfile_sb (BYPASS=1).
// A behavioural model (plain arrays updated in program order) predicts the
// read ports, busy flags and nbusy; a negedge process compares every cycle.
// Hand-computed literal checks pin the key scenarios independently.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];

  task automatic check(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: what a read of rs must return right now.
  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] rs);
    if (!rst || rs == 0) return '0;
    if (bus.wen1 && bus.waddr1 == rs) return bus.wdata1;
    if (bus.wen0 && bus.waddr0 == rs) return bus.wdata0;
    return m_reg[rs];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] rs);
    if (!rst || rs == 0) return 1'b0;
    if ((bus.wen0 && bus.waddr0 == rs) || (bus.wen1 && bus.waddr1 == rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Model state update: writes in port order (port 1 last wins),
  // then clears, then sets (set beats clear); flush overrides all.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (bus.wen0 && bus.waddr0 != 0) m_reg[bus.waddr0] <= bus.wdata0;
      if (bus.wen1 && bus.waddr1 != 0) m_reg[bus.waddr1] <= bus.wdata1;
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] <= 1'b0;
      end else begin
        if (bus.wen0) m_busy[bus.waddr0] <= 1'b0;
        if (bus.wen1) m_busy[bus.waddr1] <= 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] <= 1'b1;
        m_busy[0] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("rdata1", bus.rdata1, exp_rdata(bus.rs1));
    check("rdata2", bus.rdata2, exp_rdata(bus.rs2));
    check("busy1",  XLEN'(bus.busy1), XLEN'(exp_busy(bus.rs1)));
    check("busy2",  XLEN'(bus.busy2), XLEN'(exp_busy(bus.rs2)));
    check("nbusy",  XLEN'(bus.nbusy), XLEN'(m_count()));
  end

  task automatic idle();
    bus.wen0 = 1'b0; bus.wen1 = 1'b0;
    bus.waddr0 = '0; bus.waddr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0;
  endtask

  task automatic rand_inputs(input int flush_pct);
    bus.rs1 = AW'($urandom); bus.rs2 = AW'($urandom);
    bus.wen0 = 1'($urandom_range(0, 1)); bus.wen1 = 1'($urandom_range(0, 1));
    bus.waddr0 = AW'($urandom); bus.waddr1 = AW'($urandom);
    bus.wdata0 = $urandom; bus.wdata1 = $urandom;
    bus.iss_valid = 1'($urandom_range(0, 1)); bus.iss_rd = AW'($urandom);
    bus.flush = ($urandom_range(0, 99) < flush_pct) ? 1'b1 : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0;
    idle();
    // Reset held with random activity.
    for (int i = 0; i < 6; i++) begin
      tick(); rand_inputs(10);
      settle();
      check("rst_rdata1", bus.rdata1, 32'h0);
      check("rst_busy1", XLEN'(bus.busy1), 32'h0);
      check("rst_nbusy", XLEN'(bus.nbusy), 32'h0);
    end
    tick(); idle(); rst = 1'b1;
    // Sweep all addresses right after release.
    for (int i = 0; i < NREG; i += 2) begin
      bus.rs1 = AW'(i); bus.rs2 = AW'(i + 1);
      settle();
      check("post_rst_rdata2", bus.rdata2, 32'h0);
      tick();
    end

    // Dual write to the same address: port 1 wins, bypassed same cycle.
    bus.wen0 = 1'b1; bus.wen1 = 1'b1; bus.waddr0 = 5'd5; bus.waddr1 = 5'd5;
    bus.wdata0 = 32'hAAAA0000; bus.wdata1 = 32'h5555FFFF; bus.rs1 = 5'd5;
    settle(); check("dual_bypass", bus.rdata1, 32'h5555FFFF);
    tick(); idle();
    settle(); check("dual_stored", bus.rdata1, 32'h5555FFFF);

    // x0: write and issue to address 0 have no effect.
    tick();
    bus.wen0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hDEADBEEF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rs1 = 5'd0;
    settle(); check("x0_rdata", bus.rdata1, 32'h0); check("x0_busy", XLEN'(bus.busy1), 32'h0);
    tick(); idle();
    settle(); check("x0_rdata_next", bus.rdata1, 32'h0); check("x0_nbusy", XLEN'(bus.nbusy), 32'h0);

    // Scoreboard lifecycle on register 7.
    tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
    settle(); check("iss_same_cycle_busy", XLEN'(bus.busy1), 32'h0);
    tick(); idle();
    settle(); check("iss_busy", XLEN'(bus.busy1), 32'h1); check("iss_nbusy", XLEN'(bus.nbusy), 32'h1);
    tick(); bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h00001234;
    settle(); check("wb_busy_bypass", XLEN'(bus.busy1), 32'h0); check("wb_nbusy_hold", XLEN'(bus.nbusy), 32'h1);
    tick(); idle();
    settle(); check("wb_nbusy", XLEN'(bus.nbusy), 32'h0); check("wb_data", bus.rdata1, 32'h00001234);

    // Same-cycle set and clear of register 9 keeps it busy.
    tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.rs1 = 5'd9;
    tick(); bus.wen1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h00000099;
    settle(); check("setclr_nbusy_before", XLEN'(bus.nbusy), 32'h1);
    tick(); bus.iss_valid = 1'b0; bus.wen1 = 1'b0;
    settle(); check("setclr_busy", XLEN'(bus.busy1), 32'h1); check("setclr_nbusy", XLEN'(bus.nbusy), 32'h1);
    check("setclr_data", bus.rdata1, 32'h00000099);

    // Flush with a simultaneous issue.
    tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    tick(); bus.iss_rd = 5'd11;
    tick(); idle();
    settle(); check("three_busy", XLEN'(bus.nbusy), 32'h3);
    tick(); bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    tick(); idle(); bus.rs1 = 5'd4; bus.rs2 = 5'd9;
    settle(); check("flush_nbusy", XLEN'(bus.nbusy), 32'h0);
    check("flush_busy4", XLEN'(bus.busy1), 32'h0); check("flush_busy9", XLEN'(bus.busy2), 32'h0);
    tick(); bus.rs1 = 5'd5;
    settle(); check("flush_data_kept", bus.rdata1, 32'h5555FFFF);

    // Random traffic, model checked every cycle.
    for (int i = 0; i < 300; i++) begin
      tick(); rand_inputs(5);
    end

    // Asynchronous reset mid-cycle with writes pending.
    tick(); rand_inputs(0); bus.wen0 = 1'b1; bus.iss_valid = 1'b1;
    #2 rst = 1'b0; #1;
    check("async_rst_nbusy", XLEN'(bus.nbusy), 32'h0);
    check("async_rst_rdata1", bus.rdata1, 32'h0);
    check("async_rst_busy2", XLEN'(bus.busy2), 32'h0);
    tick(); idle(); rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(); rand_inputs(5);
    end
    tick(); idle();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two read ports, two write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. It is the next-generation architectural register file for the dual-issue core, between decode/issue (read operands, mark destination busy) and writeback (two result buses). Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width of every register.
- NREG, 32, number of registers; power of two, at least 2.
- AW, 5, address width; equals log2(NREG).
- BYPASS, 1, 1 = same-cycle write data and busy-clear are visible on read ports; 0 = reads see only registered state.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rs1, rs2  in  AW  read addresses.
- rdata1, rdata2  out  XLEN  read data, combinational.
- busy1, busy2  out  1  scoreboard status of rs1/rs2, combinational.
- wen0, wen1  in  1  write enables, writeback ports 0 and 1.
- waddr0, waddr1  in  AW  write addresses.
- wdata0, wdata1  in  XLEN  write data.
- iss_valid  in  1  issue of an instruction that writes iss_rd.
- iss_rd  in  AW  destination to mark busy.
- flush  in  1  clear the whole scoreboard (pipeline squash).
- nbusy  out  AW+1  registered count of busy registers.

## Operation
- Storage: registers 1..NREG-1, XLEN bits each. Register 0 always reads 0; writes and issues to address 0 are ignored.
- Write: at the rising edge, reg[waddrN] <= wdataN when wenN=1 and waddrN != 0. If both ports target the same nonzero address, port 1 wins.
- Read, BYPASS=0: rdataK = reg[rsK].
- Read, BYPASS=1: if rsK != 0 and matches an enabled write address, rdataK = that port's wdata. Port 1 has priority over port 0. Otherwise rdataK = reg[rsK].
- Scoreboard: one busy bit per register 1..NREG-1.
  - A set is iss_valid=1 with iss_rd != 0.
  - A clear is any enabled write to that address.
- Scoreboard priority per register at an edge: flush > set > clear > hold.
  - flush=1 clears every bit and ignores iss_valid in that cycle.
  - A set and a clear of the same register in one cycle leave it busy, because the new producer is in flight.
- busyK, BYPASS=0: busy[rsK].
- busyK, BYPASS=1: busy[rsK] AND NOT (an enabled write to rsK this cycle). busy for rsK=0 is always 0.
- nbusy: registered popcount of the busy bits, updated at the same edge as the bits. Maximum value NREG-1; no wrap.

## Timing
- Reset (rst=0, asynchronous) clears all registers and busy bits and sets nbusy=0. While reset is held and right after release, rdata1=rdata2=0 for any address, busy1=busy2=0, and nbusy=0.
- Reset asserted mid-operation discards all pending writes and issues at once. No edge is required.
- Write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Issue-to-busy latency is 1 cycle. Issue does not affect busyK in its own cycle.
- Writeback-to-not-busy latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- nbusy is valid 1 cycle after the set, clear or flush that changed it.
- No stall or handshake. Callers must not issue to a busy register they have not yet resolved. The block does not check this.

## Test plan
- Reset: hold rst=0 with random inputs, then release. Required: rdata=0, busy=0, nbusy=0 for all addresses.
- Dual write, same address: wen0=wen1=1, waddr0=waddr1=5, wdata0=0xAAAA0000, wdata1=0x5555FFFF.
  - Next cycle, rs1=5 reads 0x5555FFFF.
  - With BYPASS=1, rdata1 shows 0x5555FFFF in the write cycle itself.
- x0 behaviour: write 0xDEADBEEF to address 0, and issue with iss_rd=0. Required: rdata for rs=0 is 0, busy is 0, nbusy is unchanged.
- Scoreboard lifecycle:
  - Issue rd=7. Next cycle busy1=1 for rs1=7 and nbusy=1.
  - A write to 7 with BYPASS=1 gives busy1=0 that same cycle. Next cycle nbusy=0.
- Same-cycle set and clear: busy[9]=1, then iss_rd=9 together with wen1 waddr1=9 in one cycle. Required: busy[9] stays 1 next cycle and nbusy is unchanged.
- Flush with issue: 3 registers busy, then flush=1 together with iss_valid iss_rd=4. Required: next cycle all busy bits are 0 and nbusy=0. Register data is unchanged.
